// File: rtl/step_rate_controller.sv
// Stepper step-clock generator: decodes remote commands into step_clk with accel/decel ramp and time-boxed turns.
// Optional watchdog auto-stop is compiled in when STEP_WATCHDOG_EN is defined.
module step_rate_controller #(
   parameter int unsigned CW          = 16,
   parameter int unsigned DIV_START   = 50000,
   parameter int unsigned DIV_MIN     = 12500,
   parameter int unsigned RAMP_STEP   = 500,
   parameter int unsigned TURN_STEPS  = 512,
   parameter int unsigned WDOG_CYCLES = 5000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   input  logic [2:0] cmd,
   output logic       cmd_ready,
   output logic       step_clk,
   output logic       en,
   output logic [1:0] rotate,
   output logic       turning
);
   localparam int unsigned   TW      = $clog2(TURN_STEPS + 1);
   localparam logic [CW-1:0] START_C = CW'(DIV_START);
   localparam logic [CW-1:0] MIN_C   = CW'(DIV_MIN);
   localparam logic [CW-1:0] STEP_C  = CW'(RAMP_STEP);
   localparam logic [TW-1:0] TURN_C  = TW'(TURN_STEPS);

   typedef enum logic [1:0] {IDLE, RAMP, CRUISE, DECEL} state_t;

   state_t        state;
   logic [CW-1:0] period, div_cnt, period_dn, period_up;
   logic [TW-1:0] turn_cnt;
   logic          div_wrap, step_evt, estop, accept;
   logic          go_fwd, go_left, go_right, stop_req, wdog_fire, decel_done;

   always_comb begin
      div_wrap   = (state != IDLE) && (div_cnt == period - 1'b1);
      step_evt   = div_wrap && !step_clk;
      estop      = cmd_valid && (cmd == 3'b100);
      accept     = cmd_valid && (state != DECEL);
      go_fwd     = accept && (cmd == 3'b001);
      go_left    = accept && (cmd == 3'b010);
      go_right   = accept && (cmd == 3'b011);
      stop_req   = ((accept && (cmd == 3'b000)) || wdog_fire) && ((state == RAMP) || (state == CRUISE));
      decel_done = (state == DECEL) && step_evt && (period == START_C);
      // One extra bit keeps both ramp comparisons free of wrap-around.
      period_dn  = ({1'b0, period} < ({1'b0, MIN_C} + {1'b0, STEP_C})) ? MIN_C : period - STEP_C;
      period_up  = (({1'b0, period} + {1'b0, STEP_C}) > {1'b0, START_C}) ? START_C : period + STEP_C;
   end

   always_ff @(posedge clk) begin
      if (rst || estop) begin
         state     <= IDLE;
         period    <= START_C;
         div_cnt   <= '0;
         step_clk  <= 1'b0;
         en        <= 1'b0;
         rotate    <= 2'b00;
         turning   <= 1'b0;
         turn_cnt  <= '0;
         cmd_ready <= 1'b1;
      end else if (state == IDLE) begin
         div_cnt   <= '0;
         step_clk  <= 1'b0;
         cmd_ready <= 1'b1;
         en        <= go_fwd || go_left || go_right;
         if (go_fwd || go_left || go_right) begin
            state  <= RAMP;
            period <= START_C;
         end
         if (go_left) begin
            rotate   <= 2'b01;
            turn_cnt <= TURN_C;
            turning  <= 1'b1;
         end
         if (go_right) begin
            rotate   <= 2'b10;
            turn_cnt <= TURN_C;
            turning  <= 1'b1;
         end
      end else begin
         if (div_wrap) begin
            div_cnt  <= '0;
            step_clk <= !step_clk;
         end else begin
            div_cnt  <= div_cnt + 1'b1;
         end
         if (step_evt && (state == RAMP)) begin
            period <= period_dn;
            if (period_dn == MIN_C) state <= CRUISE;
         end
         if (step_evt && (state == DECEL)) period <= period_up;
         if (stop_req) state <= DECEL;
         // Later command loads deliberately override the step-event decrement.
         if (step_evt && (turn_cnt != '0)) begin
            turn_cnt <= turn_cnt - 1'b1;
            if (turn_cnt == TW'(1)) begin
               rotate  <= 2'b00;
               turning <= 1'b0;
            end
         end
         if (go_fwd) begin
            rotate   <= 2'b00;
            turn_cnt <= '0;
            turning  <= 1'b0;
         end
         if (go_left) begin
            rotate   <= 2'b01;
            turn_cnt <= TURN_C;
            turning  <= 1'b1;
         end
         if (go_right) begin
            rotate   <= 2'b10;
            turn_cnt <= TURN_C;
            turning  <= 1'b1;
         end
         cmd_ready <= (state == DECEL) ? decel_done : !stop_req;
         if (decel_done) begin
            state    <= IDLE;
            en       <= 1'b0;
            step_clk <= 1'b0;
            rotate   <= 2'b00;
            turning  <= 1'b0;
            turn_cnt <= '0;
            div_cnt  <= '0;
         end
      end
   end

`ifdef STEP_WATCHDOG_EN
   logic [31:0] wdog_cnt;

   always_ff @(posedge clk) begin
      if (rst || cmd_valid || (state == IDLE) || wdog_fire)
         wdog_cnt <= '0;
      else
         wdog_cnt <= wdog_cnt + 1'b1;
   end

   assign wdog_fire = !cmd_valid && (state != IDLE) && (wdog_cnt == 32'(WDOG_CYCLES - 1));
`else
   assign wdog_fire = 1'b0;
`endif

endmodule

// File: tb/tb_step_rate_controller.sv
// Bench for step_rate_controller: directed scenarios with literal expectations plus randomized commands vs a cycle model.
module tb_step_rate_controller;
   localparam int DS = 8;
   localparam int DM = 2;
   localparam int RS = 2;
   localparam int TS = 4;
   localparam int WD = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [2:0] cmd = 3'b000;
   logic       cmd_ready, step_clk, en, turning;
   logic [1:0] rotate;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   // Model: run 0 idle / 1 speeding up / 2 cruising / 3 slowing; left = cycles remaining in this half-period.
   int m_run = 0, m_per = DS, m_left = DS, m_lvl = 0, m_en = 0, m_rot = 0, m_tc = 0, m_wd = 0;

   always #5 clk = ~clk;

   step_rate_controller #(
      .CW(16), .DIV_START(DS), .DIV_MIN(DM), .RAMP_STEP(RS), .TURN_STEPS(TS), .WDOG_CYCLES(WD)
   ) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
      .step_clk(step_clk), .en(en), .rotate(rotate), .turning(turning)
   );

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit v, input bit [2:0] c);
      int nrun, nper, nleft, nlvl, nen, nrot, ntc, nwd;
      bit edge_, rise, acc, fire;
      if (r || (v && c == 3'd4)) begin
         m_run = 0; m_per = DS; m_left = DS; m_lvl = 0; m_en = 0; m_rot = 0; m_tc = 0; m_wd = 0;
         return;
      end
      nrun = m_run; nper = m_per; nleft = m_left; nlvl = m_lvl;
      nen = m_en; nrot = m_rot; ntc = m_tc; nwd = 0;
      if (m_run == 0) begin
         if (v && c >= 3'd1 && c <= 3'd3) begin
            nrun = 1; nen = 1; nper = DS; nleft = DS; nlvl = 0;
            nrot = (c == 3'd2) ? 1 : (c == 3'd3) ? 2 : 0;
            ntc  = (c == 3'd1) ? 0 : TS;
         end
      end else begin
         fire = 1'b0;
`ifdef STEP_WATCHDOG_EN
         if (v) nwd = 0;
         else if (m_wd == WD - 1) begin nwd = 0; fire = 1'b1; end
         else nwd = m_wd + 1;
`endif
         edge_ = (m_left == 1);
         rise  = edge_ && (m_lvl == 0);
         acc   = v && (m_run != 3);
         if (rise && m_run == 1) begin
            nper = (m_per - RS < DM) ? DM : m_per - RS;
            if (nper == DM) nrun = 2;
         end
         if (rise && m_run == 3) nper = (m_per + RS > DS) ? DS : m_per + RS;
         if (((acc && c == 3'd0) || fire) && m_run != 3) nrun = 3;
         if (edge_) begin nlvl = 1 - m_lvl; nleft = nper; end
         else nleft = m_left - 1;
         if (rise && m_tc > 0) begin
            ntc = m_tc - 1;
            if (ntc == 0) nrot = 0;
         end
         if (acc && c == 3'd1) begin ntc = 0;  nrot = 0; end
         if (acc && c == 3'd2) begin ntc = TS; nrot = 1; end
         if (acc && c == 3'd3) begin ntc = TS; nrot = 2; end
         if (rise && m_run == 3 && m_per == DS) begin
            nrun = 0; nen = 0; nlvl = 0; nrot = 0; ntc = 0; nleft = DS;
         end
      end
      m_run = nrun; m_per = nper; m_left = nleft; m_lvl = nlvl;
      m_en = nen; m_rot = nrot; m_tc = ntc; m_wd = nwd;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("step_clk",  16'(step_clk),  16'(m_lvl));
         chk("en",        16'(en),        16'(m_en));
         chk("rotate",    16'(rotate),    16'(m_rot));
         chk("turning",   16'(turning),   16'(m_tc != 0));
         chk("cmd_ready", 16'(cmd_ready), 16'(m_run != 3));
      end
   end

   task automatic tick(input bit r, input bit v, input logic [2:0] c);
      rst = r; cmd_valid = v; cmd = c;
      @(posedge clk);
      #1;
      model_step(r, v, c);
      rst = 1'b0; cmd_valid = 1'b0;
   endtask

   task automatic wait_rise(output int ok);
      logic prev;
      prev = step_clk;
      ok = 0;
      for (int i = 0; i < 100 && ok == 0; i++) begin
         tick(1'b0, 1'b0, 3'd0);
         if (step_clk && !prev) ok = 1;
         prev = step_clk;
      end
   endtask

   task automatic count_turn_steps(output int n);
      logic prev;
      prev = step_clk;
      n = 0;
      for (int i = 0; i < 200 && turning; i++) begin
         tick(1'b0, 1'b0, 3'd0);
         if (step_clk && !prev) n++;
         prev = step_clk;
      end
   endtask

   initial begin
      int runs[$];
      int exp_runs[6];
      int len, n, ok, k;
      logic prev;
      bit r, v;
      logic [2:0] c;

      exp_runs = '{8, 6, 6, 4, 4, 2};
      tick(1'b1, 1'b0, 3'd0);
      tick(1'b1, 1'b0, 3'd0);
      chk_en = 1'b1;
      chk("reset_outputs", 16'({cmd_ready, step_clk, en, rotate, turning}), 16'(6'b100000));

      // Ramp from idle
      tick(1'b0, 1'b1, 3'd1);
      chk("en_after_fwd", 16'(en), 16'd1);
      len = 1; prev = step_clk;
      for (int i = 0; i < 40; i++) begin
         tick(1'b0, 1'b0, 3'd0);
         if (step_clk !== prev) begin runs.push_back(len); len = 1; prev = step_clk; end
         else len++;
      end
      for (int i = 0; i < 6; i++)
         chk("ramp_half_period", 16'((runs.size() > i) ? runs[i] : -1), 16'(exp_runs[i]));

      // Reset mid-cruise, then restart
      tick(1'b1, 1'b0, 3'd0);
      tick(1'b1, 1'b0, 3'd0);
      chk("reset_mid_cruise", 16'({cmd_ready, step_clk, en, rotate, turning}), 16'(6'b100000));
      tick(1'b0, 1'b1, 3'd1);
      for (int i = 0; i < 40; i++) tick(1'b0, 1'b0, 3'd0);

      // Left turn lasts four steps
      tick(1'b0, 1'b1, 3'd2);
      chk("left_start", 16'({rotate, turning}), 16'(3'b011));
      count_turn_steps(n);
      chk("left_steps", 16'(n), 16'd4);
      chk("left_end", 16'(rotate), 16'd0);

      // Right replaces left after two steps and reloads
      tick(1'b0, 1'b1, 3'd2);
      wait_rise(ok);
      wait_rise(ok);
      tick(1'b0, 1'b1, 3'd3);
      chk("right_start", 16'({rotate, turning}), 16'(3'b101));
      count_turn_steps(n);
      chk("right_steps", 16'(n), 16'd4);

      // Stop from cruise, FWD ignored while slowing
      wait_rise(ok);
      chk("rise_seen", 16'(ok), 16'd1);
      tick(1'b0, 1'b1, 3'd0);
      n = 0;
      for (int i = 0; i < 200 && en; i++) begin
         if (i == 10) begin
            chk("decel_not_ready", 16'(cmd_ready), 16'd0);
            tick(1'b0, 1'b1, 3'd1);
         end else begin
            tick(1'b0, 1'b0, 3'd0);
         end
         n++;
      end
      chk("decel_length", 16'(n), 16'd39);
      chk("idle_after_decel", 16'({step_clk, en, cmd_ready}), 16'(3'b001));

      // ESTOP while ramping right, then fresh start
      tick(1'b0, 1'b1, 3'd3);
      repeat (5) tick(1'b0, 1'b0, 3'd0);
      chk("ramp_right", 16'(rotate), 16'd2);
      tick(1'b0, 1'b1, 3'd4);
      chk("estop_outputs", 16'({step_clk, en, rotate, turning, cmd_ready}), 16'(6'b000001));
      tick(1'b0, 1'b1, 3'd1);
      n = 0;
      for (int i = 0; i < 50 && !step_clk; i++) begin
         n++;
         tick(1'b0, 1'b0, 3'd0);
      end
      chk("restart_first_half", 16'(n), 16'd8);

      // Long run with no commands
      tick(1'b0, 1'b1, 3'd4);
      tick(1'b0, 1'b1, 3'd1);
      repeat (1000) tick(1'b0, 1'b0, 3'd0);
`ifdef STEP_WATCHDOG_EN
      chk("watchdog_idle", 16'({en, step_clk, cmd_ready}), 16'(3'b001));
`else
      chk("no_watchdog_running", 16'({en, cmd_ready}), 16'(2'b11));
      wait_rise(ok);
      n = 0;
      prev = step_clk;
      for (int i = 0; i < 50; i++) begin
         tick(1'b0, 1'b0, 3'd0);
         n++;
         if (step_clk && !prev) break;
         prev = step_clk;
      end
      chk("cruise_step_period", 16'(n), 16'd4);
`endif

      // Randomized commands against the model
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 299) == 0);
         v = ($urandom_range(0, 24) == 0);
         k = $urandom_range(0, 9);
         case (k)
            0, 1:    c = 3'd0;
            2, 3:    c = 3'd1;
            4, 5:    c = 3'd2;
            6, 7:    c = 3'd3;
            8:       c = 3'd4;
            default: c = 3'($urandom_range(5, 7));
         endcase
         tick(r, v, c);
      end

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
